// File: rtl/pix_packer_pkg.sv
// Shared definitions for the pixel stream packer and its read-side unpacker.
// Count-field sizing and beat-slot layout of a packed word.
package pix_packer_pkg;

    // Beat-count field must hold 1..n, hence one extra bit over $clog2(n).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int slice_lo(input int k, input int iw);
        return k * iw;
    endfunction

endpackage

// File: rtl/pix_packer.sv
// Write-side packer: gathers N narrow beats into one wide word for the FIFO.
// A last-flagged beat closes the word early with a partial beat count.
module pix_packer
    import pix_packer_pkg::*;
#(
    parameter int IW = 8,
    parameter int N = 4,
    localparam int CW = cnt_width(N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ival_i,
    input  logic [IW-1:0]     idata_i,
    input  logic              ilast_i,
    output logic              irdy_o,
    output logic              oval_o,
    output logic [N*IW-1:0]   odata_o,
    output logic              olast_o,
    output logic [CW-1:0]     ocnt_o,
    input  logic              ordy_i
);

    localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

    logic [N*IW-1:0] acc;
    logic [N*IW-1:0] merged;
    logic [CW-1:0]   fcnt;
    logic            acc_in;
    logic            done;

    assign irdy_o = ~rst_i & (~oval_o | ordy_i);
    assign acc_in = ival_i & irdy_o;
    assign done   = acc_in & ((fcnt == LAST_SLOT) | ilast_i);

    // Current accumulator with the incoming beat dropped into its slot.
    always_comb begin
        merged = acc;
        merged[slice_lo(int'(fcnt), IW) +: IW] = idata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc     <= '0;
            fcnt    <= '0;
            oval_o  <= 1'b0;
            odata_o <= '0;
            olast_o <= 1'b0;
            ocnt_o  <= '0;
        end else if (done) begin
            // New word may replace one leaving this cycle: no bubble.
            acc     <= '0;
            fcnt    <= '0;
            oval_o  <= 1'b1;
            odata_o <= merged;
            olast_o <= ilast_i;
            ocnt_o  <= fcnt + CW'(1);
        end else begin
            if (acc_in) begin
                acc  <= merged;
                fcnt <= fcnt + CW'(1);
            end
            if (oval_o && ordy_i) begin
                oval_o <= 1'b0;
            end
        end
    end

endmodule
